// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_queue
// Purpose  : Fetch-to-decode instruction buffer. Captures {inst, pc} pairs
//            that fetch marks valid, presents them to decode in strict FIFO
//            order, absorbs decode stalls and raises a full indication that
//            fetch uses as its stall. Writeback flushes it on mispredict or
//            exception.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1        rising-edge clock
//   reset        in   1        asynchronous active-high reset
//   inst_e_      in   1        active-low valid of fetched instruction
//   inst         in   INST     fetched instruction word
//   inst_pc      in   ADDR     PC of inst
//   iq_full      out  1        queue full; fetch holds its instruction
//   dec_inst_e_  out  1        active-low valid of head entry
//   dec_inst     out  INST     head instruction (0 when empty)
//   dec_pc       out  ADDR     head PC (0 when empty)
//   dec_stall    in   1        decode stall; head is not consumed
//   wb_flush_    in   1        active-low flush from writeback
//   iq_count     out  CNT_W    current occupancy
// ============================================================================
module inst_queue #(
  parameter int ADDR  = 32,
  parameter int INST  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inst_e_,
  input  logic [INST-1:0]          inst,
  input  logic [ADDR-1:0]          inst_pc,
  output logic                     iq_full,
  output logic                     dec_inst_e_,
  output logic [INST-1:0]          dec_inst,
  output logic [ADDR-1:0]          dec_pc,
  input  logic                     dec_stall,
  input  logic                     wb_flush_,
  output logic [$clog2(DEPTH):0]   iq_count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [INST-1:0]    inst_mem_q [DEPTH];
  logic [ADDR-1:0]    pc_mem_q   [DEPTH];

  logic [c_PTR_W-1:0] head_q,  head_d;
  logic [c_PTR_W-1:0] tail_q,  tail_d;
  logic [c_CNT_W-1:0] count_q, count_d;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  // Full/empty come straight from the registered count, so neither fetch's
  // stall nor decode's valid has a combinational path from the other side.
  assign w_full  = (count_q == c_CNT_FULL);
  assign w_empty = (count_q == c_CNT_ZERO);

  // A push is blocked whenever the queue is full at the edge, even if decode
  // pops in the same cycle: no full-bypass. Flush suppresses both sides.
  assign w_push = !inst_e_ && !w_full && wb_flush_;
  assign w_pop  = !w_empty && !dec_stall && wb_flush_;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (!wb_flush_) begin
      // Entry contents are left as-is; pointers and count alone define
      // what is live.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Power-of-two depth: pointers wrap from DEPTH-1 to 0 naturally.
      if (w_push) begin
        tail_d = tail_q + c_PTR_ONE;
      end
      if (w_pop) begin
        head_d = head_q + c_PTR_ONE;
      end
      unique case ({w_push, w_pop})
        2'b10:   count_d = count_q + c_CNT_ONE;
        2'b01:   count_d = count_q - c_CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Pointer / count registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Entry storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (w_push) begin
      inst_mem_q[tail_q] <= inst;
      pc_mem_q[tail_q]   <= inst_pc;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (registered state only; a pushed entry shows up one cycle later)
  // --------------------------------------------------------------------------
  always_comb begin
    iq_full     = w_full;
    dec_inst_e_ = w_empty;
    iq_count    = count_q;
    dec_inst    = '0;
    dec_pc      = '0;
    if (!w_empty) begin
      dec_inst = inst_mem_q[head_q];
      dec_pc   = pc_mem_q[head_q];
    end
  end

endmodule
`default_nettype wire

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Fetch-to-decode instruction buffer, directly downstream of fetch_ctrl.
- Captures instruction/PC pairs that fetch marks valid and presents them in order to decode, absorbing decode stalls.
- Raises a full indication that fetch uses as a stall.
- Flushed by writeback on mispredict or exception.

Parameters:
- ADDR, `AddrWidth, PC width.
- INST, 32, instruction word width.
- DEPTH, 4, entry count; power of two, at least 2.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous active-high reset.
- inst_e_  in  1  active-low valid for the fetched instruction, from fetch_ctrl.
- inst  in  INST  fetched instruction word.
- inst_pc  in  ADDR  PC of inst.
- iq_full  out  1  queue full; fetch must hold its current instruction while high.
- dec_inst_e_  out  1  active-low valid of the head entry, to decode.
- dec_inst  out  INST  head instruction.
- dec_pc  out  ADDR  head PC.
- dec_stall  in  1  active-high decode stall; head is not consumed.
- wb_flush_  in  1  active-low flush from writeback.
- iq_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer of DEPTH entries {inst, pc}.
  - Pointers head and tail are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
  - count is $clog2(DEPTH)+1 bits.
- Reset (async, high): head=tail=0, count=0, all entries cleared to 0.
  - Outputs during and after reset: iq_full=0, dec_inst_e_=1, dec_inst=0, dec_pc=0, iq_count=0.
  - Reset asserted mid-operation discards all entries immediately.
- Push: push = !inst_e_ && !iq_full && wb_flush_.
  - Writes {inst, inst_pc} at tail; tail+1.
  - If inst_e_ is low while iq_full is high, the input is ignored. Fetch is required to hold it, so it is not lost.
- Pop: pop = !dec_inst_e_ && !dec_stall && wb_flush_. Advances head+1.
- Count update: count += push - pop.
  - Simultaneous push and pop leaves count unchanged and moves both pointers.
  - Simultaneous push and pop is legal at any occupancy below DEPTH.
  - At count==DEPTH, push is blocked even if pop occurs that cycle (no full-bypass). This keeps iq_full registered-derived with no combinational path from dec_stall to fetch.
- No bypass: a pushed entry becomes visible on dec_* one cycle after the push edge. Minimum fetch-to-decode latency is 1 cycle.
- Outputs are derived only from registered state:
  - iq_full = (count==DEPTH).
  - dec_inst_e_ = (count==0).
  - dec_inst/dec_pc = entry[head] when count!=0, else 0.
  - iq_count = count.
- Flush (wb_flush_ low at a clock edge): head=tail=count=0.
  - Same-cycle push and pop are suppressed.
  - Entry contents need not be cleared.
  - From the following cycle: dec_inst_e_=1, iq_full=0.
  - Flush has priority over everything except reset.
- dec_stall with an empty queue has no effect.
- Order is strictly FIFO; no entry is duplicated or dropped except by flush or reset.

Test Plan:
- Reset then idle: hold reset high 1 cycle, then release with inst_e_=1 for 5 cycles.
  -> iq_full=0, dec_inst_e_=1, dec_inst=0, dec_pc=0, iq_count=0 throughout.
- Single push: inst_e_=0, inst=32'h00000013, inst_pc=32'h100 for 1 cycle, dec_stall=0.
  -> next cycle dec_inst_e_=0, dec_inst=32'h13, dec_pc=32'h100; following cycle dec_inst_e_=1, iq_count=0.
- Fill and wrap: dec_stall=1, push PCs 0x0,0x4,0x8,0xC.
  -> iq_count=4, iq_full=1.
  - A 5th push of PC 0x10 is held by the bench while full.
  - Release dec_stall: dec_pc sequence is 0x0,0x4,0x8,0xC,0x10 on consecutive cycles; tail wraps to 1.
- Simultaneous push/pop: with count=2 and dec_stall=0, push every cycle for 6 cycles.
  -> iq_count stays 2; dec_pc follows input PC with 2-cycle offset; no gaps.
- Flush with push: count=3, assert wb_flush_=0 for 1 cycle with inst_e_=0 and inst_pc=0x200.
  -> next cycle iq_count=0, dec_inst_e_=1, 0x200 not present.
  - Push 0x300 the following cycle -> dec_pc=0x300 one cycle later.
- Async reset mid-operation: count=3, raise reset between clock edges.
  -> dec_inst_e_=1, iq_count=0 immediately, without waiting for a clock edge.
  - After release, first push appears as the head entry.
